// File: rtl/pe_feed.sv
// pe_feed: splits one 64-bit host stream (header + interleaved A/B operand words)
// onto the two input streams of the vector PE. The header goes to both streams in
// the same cycle, A words go to D and B words go to D2. Back pressure from the PE
// is registered once before use. Zero-length headers are dropped with an ERR pulse.
// Optional feature macro: PE_FEED_STATS_EN enables the forwarded-packet counter.
module pe_feed (
  input  logic        CLK,
  input  logic        SYS_RST,
  input  logic [63:0] S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [63:0] D,
  output logic        D_VALID,
  input  logic        D_BP,
  output logic [63:0] D2,
  output logic        D2_VALID,
  input  logic        D2_BP,
  output logic        BUSY,
  output logic        ERR,
  output logic [31:0] PKT_CNT
);

  typedef enum logic [1:0] {StIdle, StA, StB} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic        bp_r, bp2_r;
  logic        s_ready;
  logic        accept;
  logic [63:0] d_d, d2_d;
  logic        d_valid_d, d2_valid_d;
  logic        err_d;
  logic        hdr_fwd;

  // Ready depends only on state and the registered back pressure.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StIdle:  s_ready = ~bp_r & ~bp2_r;
      StA:     s_ready = ~bp_r;
      StB:     s_ready = ~bp2_r;
      default: s_ready = 1'b0;
    endcase
  end

  // Ready is held low while reset is asserted so the host sees no accept window.
  assign S_READY = s_ready & ~SYS_RST;
  assign accept  = S_VALID & s_ready;
  assign BUSY    = (state_q != StIdle);

  // Next-state, remaining-pair count and output register loads.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    d_d        = D;
    d2_d       = D2;
    d_valid_d  = 1'b0;
    d2_valid_d = 1'b0;
    err_d      = 1'b0;
    hdr_fwd    = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (S_DATA[31:0] != 32'd0) begin
            d_d        = S_DATA;
            d2_d       = S_DATA;
            d_valid_d  = 1'b1;
            d2_valid_d = 1'b1;
            rem_d      = S_DATA[31:0];
            hdr_fwd    = 1'b1;
            state_d    = StA;
          end else begin
            // Zero-length packet would hang the PE: swallow it.
            err_d = 1'b1;
          end
        end
      end
      StA: begin
        if (accept) begin
          d_d       = S_DATA;
          d_valid_d = 1'b1;
          state_d   = StB;
        end
      end
      StB: begin
        if (accept) begin
          d2_d       = S_DATA;
          d2_valid_d = 1'b1;
          rem_d      = rem_q - 32'd1;
          state_d    = (rem_q == 32'd1) ? StIdle : StA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, back-pressure and output registers.
  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q  <= StIdle;
      rem_q    <= 32'd0;
      bp_r     <= 1'b0;
      bp2_r    <= 1'b0;
      D        <= 64'd0;
      D2       <= 64'd0;
      D_VALID  <= 1'b0;
      D2_VALID <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      bp_r     <= D_BP;
      bp2_r    <= D2_BP;
      D        <= d_d;
      D2       <= d2_d;
      D_VALID  <= d_valid_d;
      D2_VALID <= d2_valid_d;
      ERR      <= err_d;
    end
  end

`ifdef PE_FEED_STATS_EN
  logic [31:0] pkt_cnt_q;

  // Count forwarded headers; wraps at 32 bits, cleared only by reset.
  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      pkt_cnt_q <= 32'd0;
    end else if (hdr_fwd) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign PKT_CNT = pkt_cnt_q;
`else
  logic unused_hdr_fwd;
  assign unused_hdr_fwd = hdr_fwd;
  assign PKT_CNT        = 32'd0;
`endif

endmodule

// File: doc/pe_feed.md
# pe_feed

Stream splitter that sits in front of the two-input vector PE. It takes one 64-bit host stream holding a header word followed by interleaved operand pairs, and distributes it onto the PE's D and D2 input streams. The header is duplicated onto both streams, A operands go to D and B operands go to D2. It honours the PE's prog_full-style back pressure (D_BP/D2_BP) and drops malformed zero-length packets, which would otherwise hang the PE.

## Interface
- No parameters.
- CLK  in  1  system clock; all logic on rising edge.
- SYS_RST  in  1  reset, asynchronous, active-high.
- S_DATA  in  64  host stream word.
- S_VALID  in  1  S_DATA valid.
- S_READY  out  1  word accepted on a rising edge when S_VALID & S_READY.
- D  out  64  to PE D input: header, then A words.
- D_VALID  out  1  one-cycle strobe per D word.
- D_BP  in  1  PE fifo1 almost-full.
- D2  out  64  to PE D2 input: header, then B words.
- D2_VALID  out  1  one-cycle strobe per D2 word.
- D2_BP  in  1  PE fifo2 almost-full.
- BUSY  out  1  high while a packet is in progress (state ≠ IDLE).
- ERR  out  1  one-cycle pulse when a zero-length header is dropped.
- PKT_CNT  out  32  count of packets whose header was forwarded (see Configuration).

## Operation
- Packet format on S:
  - Header word H; N = H[31:0] = number of operand pairs.
  - Then 2N words in the order A0, B0, A1, B1, …
- D_BP and D2_BP are registered once (BP_R, BP2_R). Every decision uses the registered copies.
- **IDLE** (reset state)
  - S_READY = ~BP_R & ~BP2_R.
  - On accept with N≠0: drive D=D2=H and D_VALID=D2_VALID=1 next cycle; load REM=N; go to **A**.
  - On accept with N=0: consume H and emit nothing. Pulse ERR next cycle. Stay in IDLE.
- **A**
  - S_READY = ~BP_R.
  - On accept: D=S_DATA and D_VALID=1 next cycle; go to **B**.
- **B**
  - S_READY = ~BP2_R.
  - On accept: D2=S_DATA and D2_VALID=1 next cycle; REM ← REM−1.
  - If REM==1 before the decrement, go to IDLE; otherwise go to A.
- REM is 32-bit and unsigned. It never wraps, because N=0 never enters A.
- D and D2 hold their last value when not valid. Only the VALID strobes are meaningful.
- Header words on D and D2 are emitted in the same cycle, because the PE pops both fifos together.
- Reset in mid-packet returns the block to IDLE and abandons the partial packet. The PE must be reset concurrently (PE_RST); that is the system's responsibility.

## Timing
- Reset values: S_READY=0, D_VALID=0, D2_VALID=0, D=0, D2=0, BUSY=0, ERR=0, PKT_CNT=0, BP_R=BP2_R=0, REM=0.
- S_READY is combinational from state and the BP registers. It does not depend on S_VALID.
- Latency is 1 cycle from accept edge to VALID. Throughput is 1 word per cycle with no BP.
  - Full packet: 1+2N accepted words → 1+2N cycles minimum.
  - Back-to-back packets run with no bubble: the header can be accepted in the cycle after the last B word.
- Back-pressure slack: after D_BP rises, at most 2 more words are written to D (one from the BP register, one in the output register). The same holds for D2. The PE's prog_full threshold must leave ≥2 entries free.
- BP asserted in A stalls only the A accept; an already-emitted word is not retracted.
- BUSY is high from the cycle after header accept until the cycle after the last B accept.

## Configuration
- PE_FEED_STATS_EN
  - Defined: PKT_CNT increments, with 32-bit wrap, on every forwarded header (N≠0). It is cleared only by SYS_RST.
  - Undefined: PKT_CNT is tied to 0 and the counter is not synthesized.
  - All other behaviour is identical in both cases.

## Test plan
- **Basic packet.** Send H=2, then A0=0x10, B0=0x20, A1=0x11, B1=0x21, with S_VALID held high and BP=0.
  - D sequence: 2, 0x10, 0x11.
  - D2 sequence: 2, 0x20, 0x21.
  - Header VALIDs coincide. 5 accepts in 5 cycles. BUSY falls after B1.
- **Back pressure.** Assert D_BP for 6 cycles in the middle of an N=4 packet.
  - S_READY drops 1 cycle after D_BP in state A.
  - ≤2 extra D words issue after D_BP rises.
  - No word is lost or duplicated; final D2 word count is 5.
- **Zero length.** Send H=0, then H=1, A=0x5, B=0x6.
  - ERR pulses exactly once, and no VALID strobes occur for the first header.
  - Second packet: D = 1, 5 and D2 = 1, 6.
- **Reset mid-packet.** Send H=3 and one pair, then assert SYS_RST asynchronously mid-cycle.
  - Outputs go to 0 immediately.
  - After release, state is IDLE, and a new H=1 packet is forwarded correctly.
- **Back-to-back.** Three N=1 packets sent with no gaps.
  - 9 accepts in 9 cycles.
  - With PE_FEED_STATS_EN defined, PKT_CNT=3; without it, PKT_CNT=0.
- **With the PE.** Drive pe_feed into the PE using H=4, A=0x10..0x13, B=0x20..0x23.
  - PE output Q = 4, 0x30, 0x32, 0x34, 0x36.
